hvgen_param: RTL and testbench
==============================

Name: hvgen_param

Overview:
- Parametrised raster timing generator for the arcade cores; successor to the fixed 512x512-count generator with jump-back sync.
- Produces pixel/line counters for the game core, blank and sync signals, and blank-gated RGB for arcade_video.
- Adds configurable geometry, frame-synchronous latching of the H/V position offsets, sync-window clamping, selectable core pixel latency, and line/frame strobes.

Parameters:
RGB_W, 12, RGB bus width
HCW, 9, horizontal counter/HPOS width
VCW, 9, vertical counter/VPOS width
H_TOTAL, 384, pixel clocks per line
H_ACT, 256, active pixels per line (hcnt 0..H_ACT-1)
H_SB, 288, HSYNC start at HOFFS=0
H_SW, 32, HSYNC width in pixels
H_STEP, 2, pixels per HOFFS step
V_TOTAL, 262, lines per frame
V_ACT, 224, active lines (vcnt 0..V_ACT-1)
V_SB, 226, VSYNC start line at VOFFS=0
V_SW, 4, VSYNC width in lines
V_STEP, 4, lines per VOFFS step
H_LEAD, 0, HPOS = hcnt + H_LEAD (mod 2^HCW); fetch lead for the core
PIPE, 1, core pixel latency in PCEN ticks (1..8)

Ports:
MCLK  in  1  system clock
RESET  in  1  synchronous active-high reset
PCEN  in  1  pixel clock enable; all timing advances only when high
HOFFS  in  5  horizontal sync offset (steps)
VOFFS  in  3  vertical sync offset (steps)
iRGB  in  RGB_W  pixel from game core
HPOS  out  HCW  pixel position to core (combinational from hcnt)
VPOS  out  VCW  line position to core (= vcnt)
oRGB  out  RGB_W  registered pixel, zero during blank
HBLK  out  1  horizontal blank, active high
VBLK  out  1  vertical blank, active high
HSYN  out  1  horizontal sync, active low
VSYN  out  1  vertical sync, active low
LSTB  out  1  line-start strobe, one MCLK wide
FSTB  out  1  frame-start strobe, one MCLK wide

Behaviour:
- Clock and reset: one clock MCLK; RESET is synchronous, active-high.
- Reset values: hcnt=0, vcnt=0, latched offsets=0, delay pipeline filled with blank=1 and sync=1; HBLK=1, VBLK=1, HSYN=1, VSYN=1, oRGB=0, LSTB=0, FSTB=0.
- Reset asserted mid-frame: the same values apply on the next MCLK edge, independent of PCEN.
- Counters:
  - On a PCEN tick, hcnt increments.
  - At H_TOTAL-1, hcnt wraps to 0 and vcnt increments.
  - At V_TOTAL-1 on a line wrap, vcnt wraps to 0.
- Offset latch:
  - HOFFS and VOFFS are captured into hoff_l/voff_l only on the PCEN tick where hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1.
  - Changes at any other time have no effect until the next frame.
- Sync window:
  - hs_beg = H_SB + hoff_l*H_STEP, computed at HCW+2 bits.
  - If hs_beg+H_SW > H_TOTAL, then hs_beg = H_TOTAL-H_SW.
  - vs_beg is computed the same way from V_SB, voff_l, V_STEP, V_SW and V_TOTAL.
- Raw timing:
  - hb = (hcnt >= H_ACT); vb = (vcnt >= V_ACT).
  - hs_n = 0 iff hs_beg <= hcnt < hs_beg+H_SW.
  - vs_n = 0 iff vs_beg <= vcnt < vs_beg+V_SW; changes only at line boundaries.
- Pipeline:
  - hb, vb, hs_n and vs_n pass through a PIPE-deep shift register clocked on PCEN.
  - The stage-PIPE outputs drive HBLK, VBLK, HSYN and VSYN.
  - On the same PCEN edge: oRGB <= (HBLK_next | VBLK_next) ? 0 : iRGB.
  - The pixel for counter value x must be on iRGB at the PIPE-th PCEN edge after hcnt=x; oRGB and HBLK/VBLK for x update on that edge.
- Strobes:
  - LSTB = 1 for the single MCLK cycle after a PCEN tick in which hcnt wrapped to 0.
  - FSTB = 1 likewise when both hcnt and vcnt wrap.
  - Both clear on the next MCLK regardless of PCEN; they are undelayed by PIPE.
- PCEN low: counters, pipeline, oRGB and sync/blank outputs hold.
- Legality, enforced by an elaboration-time error:
  - H_ACT < H_TOTAL <= 2^HCW; V_ACT < V_TOTAL <= 2^VCW.
  - H_SB+H_SW <= H_TOTAL; V_SB+V_SW <= V_TOTAL.
  - 1 <= PIPE <= 8.

Test Plan:
- Defaults, PCEN=1, HOFFS=0/VOFFS=0 -> line period 384 MCLK; HBLK low for 256 cycles starting 1 cycle after hcnt=0; HSYN low hcnt 288..319 (+1 delay); VSYN low lines 226..229; FSTB every 100608 cycles.
- HOFFS=5 latched at frame start -> HSYN falls at hcnt 298, rises at 330; width stays 32.
- H_STEP=4 override, HOFFS=31 -> raw 412 clamps to hs_beg=352; HSYN low hcnt 352..383.
- Change HOFFS 0->10 at vcnt=100 -> HSYN stays at 288 through vcnt=261; moves to 308 from vcnt=0 of the next frame.
- PCEN one-in-8 -> all periods x8; outputs constant between ticks; LSTB exactly 1 MCLK wide.
- PIPE=3, iRGB=hFFF, then RESET pulsed at vcnt=50, hcnt=100 -> oRGB=hFFF only while HBLK=VBLK=0, h000 otherwise. After RESET: HPOS=0, HBLK=1, HSYN=1 on the next MCLK; active output resumes 3 ticks after restart.

Source files
------------

// File: rtl/hvgen_param.sv
// Parametrised raster timing generator: counters, blank/sync with offsets,
// PIPE-aligned blank-gated RGB, and line/frame strobes.
module hvgen_param #(
    parameter int RGB_W   = 12,
    parameter int HCW     = 9,
    parameter int VCW     = 9,
    parameter int H_TOTAL = 384,
    parameter int H_ACT   = 256,
    parameter int H_SB    = 288,
    parameter int H_SW    = 32,
    parameter int H_STEP  = 2,
    parameter int V_TOTAL = 262,
    parameter int V_ACT   = 224,
    parameter int V_SB    = 226,
    parameter int V_SW    = 4,
    parameter int V_STEP  = 4,
    parameter int H_LEAD  = 0,
    parameter int PIPE    = 1
) (
    input  logic             MCLK,
    input  logic             RESET,
    input  logic             PCEN,
    input  logic [4:0]       HOFFS,
    input  logic [2:0]       VOFFS,
    input  logic [RGB_W-1:0] iRGB,
    output logic [HCW-1:0]   HPOS,
    output logic [VCW-1:0]   VPOS,
    output logic [RGB_W-1:0] oRGB,
    output logic             HBLK,
    output logic             VBLK,
    output logic             HSYN,
    output logic             VSYN,
    output logic             LSTB,
    output logic             FSTB
);

    localparam int HW = HCW + 2;
    localparam int VW = VCW + 2;
    localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);
    localparam logic [VCW-1:0] V_LAST = VCW'(V_TOTAL - 1);

    generate
        if (!(H_ACT < H_TOTAL && H_TOTAL <= (1 << HCW))) begin : g_bad_h
            $error("hvgen_param: illegal horizontal geometry");
        end
        if (!(V_ACT < V_TOTAL && V_TOTAL <= (1 << VCW))) begin : g_bad_v
            $error("hvgen_param: illegal vertical geometry");
        end
        if (H_SB + H_SW > H_TOTAL || V_SB + V_SW > V_TOTAL) begin : g_bad_s
            $error("hvgen_param: sync window exceeds total");
        end
        if (PIPE < 1 || PIPE > 8) begin : g_bad_p
            $error("hvgen_param: PIPE out of range");
        end
    endgenerate

    logic [HCW-1:0] hcnt;
    logic [VCW-1:0] vcnt;
    logic [4:0]     hoff_l;
    logic [2:0]     voff_l;
    logic           h_wrap;
    logic           v_wrap;

    assign h_wrap = (hcnt == H_LAST);
    assign v_wrap = (vcnt == V_LAST);

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            hcnt   <= '0;
            vcnt   <= '0;
            hoff_l <= '0;
            voff_l <= '0;
        end else if (PCEN) begin
            hcnt <= h_wrap ? '0 : hcnt + 1'b1;
            if (h_wrap) begin
                vcnt <= v_wrap ? '0 : vcnt + 1'b1;
            end
            // Offsets only move at the frame boundary so a frame never tears
            if (h_wrap && v_wrap) begin
                hoff_l <= HOFFS;
                voff_l <= VOFFS;
            end
        end
    end

    logic [HW-1:0] hs_raw;
    logic [HW-1:0] hs_beg;
    logic [HW-1:0] hcnt_x;
    logic [VW-1:0] vs_raw;
    logic [VW-1:0] vs_beg;
    logic [VW-1:0] vcnt_x;
    logic          hb;
    logic          vb;
    logic          hs_n;
    logic          vs_n;

    assign hs_raw = HW'(H_SB) + HW'(hoff_l) * HW'(H_STEP);
    assign vs_raw = VW'(V_SB) + VW'(voff_l) * VW'(V_STEP);

    // Clamp so the whole pulse stays inside the line/frame
    assign hs_beg = ({1'b0, hs_raw} + (HW+1)'(H_SW) > (HW+1)'(H_TOTAL))
                  ? HW'(H_TOTAL - H_SW) : hs_raw;
    assign vs_beg = ({1'b0, vs_raw} + (VW+1)'(V_SW) > (VW+1)'(V_TOTAL))
                  ? VW'(V_TOTAL - V_SW) : vs_raw;

    assign hcnt_x = HW'(hcnt);
    assign vcnt_x = VW'(vcnt);

    assign hb   = (hcnt >= HCW'(H_ACT));
    assign vb   = (vcnt >= VCW'(V_ACT));
    assign hs_n = !(hcnt_x >= hs_beg && hcnt_x < hs_beg + HW'(H_SW));
    assign vs_n = !(vcnt_x >= vs_beg && vcnt_x < vs_beg + VW'(V_SW));

    logic [3:0] pipe     [PIPE];
    logic [3:0] stage_in [PIPE];

    always_comb begin
        stage_in[0] = {hb, vb, hs_n, vs_n};
        for (int i = 1; i < PIPE; i++) begin
            stage_in[i] = pipe[i-1];
        end
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            for (int i = 0; i < PIPE; i++) begin
                pipe[i] <= 4'hF;
            end
            oRGB <= '0;
        end else if (PCEN) begin
            for (int i = 0; i < PIPE; i++) begin
                pipe[i] <= stage_in[i];
            end
            oRGB <= (stage_in[PIPE-1][3] | stage_in[PIPE-1][2]) ? '0 : iRGB;
        end
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            LSTB <= 1'b0;
            FSTB <= 1'b0;
        end else begin
            LSTB <= PCEN & h_wrap;
            FSTB <= PCEN & h_wrap & v_wrap;
        end
    end

    assign {HBLK, VBLK, HSYN, VSYN} = pipe[PIPE-1];
    assign HPOS = hcnt + HCW'(H_LEAD);
    assign VPOS = vcnt;

endmodule

// File: tb/tb_hvgen_param.sv
// Directed bench for hvgen_param on a reduced 48x20 raster with PIPE=3,
// H_STEP=4 and H_LEAD=2 so several frames fit in a short run.
module tb_hvgen_param;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        PCEN = 1'b0;
    logic [4:0]  HOFFS = '0;
    logic [2:0]  VOFFS = '0;
    logic [11:0] iRGB = '0;
    logic [5:0]  HPOS;
    logic [4:0]  VPOS;
    logic [11:0] oRGB;
    logic        HBLK, VBLK, HSYN, VSYN, LSTB, FSTB;

    int compared = 0;
    int mism = 0;
    int n = 0;
    bit ticked = 0;
    int hoff_f[8];
    int voff_f[8];

    hvgen_param #(
        .RGB_W(12), .HCW(6), .VCW(5),
        .H_TOTAL(48), .H_ACT(32), .H_SB(36), .H_SW(4), .H_STEP(4),
        .V_TOTAL(20), .V_ACT(14), .V_SB(15), .V_SW(2), .V_STEP(1),
        .H_LEAD(2), .PIPE(3)
    ) dut (
        .MCLK(clk), .RESET(RESET), .PCEN(PCEN),
        .HOFFS(HOFFS), .VOFFS(VOFFS), .iRGB(iRGB),
        .HPOS(HPOS), .VPOS(VPOS), .oRGB(oRGB),
        .HBLK(HBLK), .VBLK(VBLK), .HSYN(HSYN), .VSYN(VSYN),
        .LSTB(LSTB), .FSTB(FSTB)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, n=%0d", n);
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] rgb_of(int k);
        return 12'(k * 157 + 11);
    endfunction

    function automatic int hs_beg(int o);
        int r = 36 + o * 4;
        return (r + 4 > 48) ? 44 : r;
    endfunction

    function automatic int vs_beg(int o);
        int r = 15 + o;
        return (r + 2 > 20) ? 18 : r;
    endfunction

    // Expected {HBLK,VBLK,HSYN,VSYN} after k pixel ticks since reset
    function automatic logic [3:0] exp_tim(int k);
        int q, h, v, f, hb0, vb0;
        if (k < 3) return 4'b1111;
        q = k - 3;
        h = q % 48;
        v = (q / 48) % 20;
        f = q / 960;
        hb0 = hs_beg(hoff_f[f]);
        vb0 = vs_beg(voff_f[f]);
        return {h >= 32, v >= 14,
                !(h >= hb0 && h < hb0 + 4),
                !(v >= vb0 && v < vb0 + 2)};
    endfunction

    function automatic logic [11:0] exp_rgb(int k);
        logic [3:0] t = exp_tim(k);
        return (t[3] | t[2]) ? 12'h000 : rgb_of(k);
    endfunction

    task automatic step(input logic pe, input logic rst);
        @(negedge clk);
        RESET = rst;
        PCEN = pe;
        iRGB = pe ? rgb_of(n + 1) : 12'hA5A;
        @(posedge clk);
        #1;
        ticked = pe && !rst;
        if (rst) begin
            n = 0;
            foreach (hoff_f[i]) begin
                hoff_f[i] = 0;
                voff_f[i] = 0;
            end
        end else if (pe) begin
            n++;
            if (n % 960 == 0) begin
                hoff_f[n / 960] = int'(HOFFS);
                voff_f[n / 960] = int'(VOFFS);
            end
        end
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        compared++; if (HPOS !== 6'd2) begin mism++; $display("FAIL reset_hpos got %0d exp 2", HPOS); end
        compared++; if (VPOS !== 5'd0) begin mism++; $display("FAIL reset_vpos got %0d exp 0", VPOS); end
        compared++; if (HBLK !== 1'b1) begin mism++; $display("FAIL reset_hblk got %b exp 1", HBLK); end
        compared++; if (VBLK !== 1'b1) begin mism++; $display("FAIL reset_vblk got %b exp 1", VBLK); end
        compared++; if (HSYN !== 1'b1) begin mism++; $display("FAIL reset_hsyn got %b exp 1", HSYN); end
        compared++; if (VSYN !== 1'b1) begin mism++; $display("FAIL reset_vsyn got %b exp 1", VSYN); end
        compared++; if (oRGB !== 12'h000) begin mism++; $display("FAIL reset_rgb got %h exp 000", oRGB); end
        compared++; if (LSTB !== 1'b0) begin mism++; $display("FAIL reset_lstb got %b exp 0", LSTB); end
        compared++; if (FSTB !== 1'b0) begin mism++; $display("FAIL reset_fstb got %b exp 0", FSTB); end
    endtask

    // Frame 0: counters, strobes, default sync; offsets changed mid-frame
    task automatic test_counters();
        logic [3:0] t;
        HOFFS = 5'd0;
        VOFFS = 3'd0;
        while (n < 960) begin
            if (n == 500) begin
                HOFFS = 5'd1;
                VOFFS = 3'd2;
            end
            step(1'b1, 1'b0);
            t = exp_tim(n);
            compared++; if (HPOS !== 6'((n % 48) + 2)) begin mism++; $display("FAIL cnt_hpos n=%0d got %0d exp %0d", n, HPOS, (n % 48) + 2); end
            compared++; if (VPOS !== 5'((n / 48) % 20)) begin mism++; $display("FAIL cnt_vpos n=%0d got %0d exp %0d", n, VPOS, (n / 48) % 20); end
            compared++; if (LSTB !== (n % 48 == 0)) begin mism++; $display("FAIL cnt_lstb n=%0d got %b", n, LSTB); end
            compared++; if (FSTB !== (n % 960 == 0)) begin mism++; $display("FAIL cnt_fstb n=%0d got %b", n, FSTB); end
            compared++; if (HSYN !== t[1]) begin mism++; $display("FAIL cnt_hsyn n=%0d got %b exp %b", n, HSYN, t[1]); end
            compared++; if (VSYN !== t[0]) begin mism++; $display("FAIL cnt_vsyn n=%0d got %b exp %b", n, VSYN, t[0]); end
        end
    endtask

    // Frame 1 uses HOFFS=1/VOFFS=2; a mid-frame change must not apply yet
    task automatic test_sync_offset();
        logic [3:0] t;
        while (n < 1920) begin
            if (n == 1500) begin
                HOFFS = 5'd31;
                VOFFS = 3'd7;
            end
            step(1'b1, 1'b0);
            t = exp_tim(n);
            compared++; if ({HBLK, VBLK} !== t[3:2]) begin mism++; $display("FAIL off_blank n=%0d got %b%b exp %b", n, HBLK, VBLK, t[3:2]); end
            compared++; if (HSYN !== t[1]) begin mism++; $display("FAIL off_hsyn n=%0d got %b exp %b", n, HSYN, t[1]); end
            compared++; if (VSYN !== t[0]) begin mism++; $display("FAIL off_vsyn n=%0d got %b exp %b", n, VSYN, t[0]); end
        end
    endtask

    // Frame 2: offsets 31/7 clamp to the end of line/frame; RGB gating
    task automatic test_clamp_rgb();
        logic [3:0] t;
        while (n < 2880) begin
            step(1'b1, 1'b0);
            t = exp_tim(n);
            compared++; if ({HBLK, VBLK} !== t[3:2]) begin mism++; $display("FAIL clamp_blank n=%0d got %b%b exp %b", n, HBLK, VBLK, t[3:2]); end
            compared++; if (HSYN !== t[1]) begin mism++; $display("FAIL clamp_hsyn n=%0d got %b exp %b", n, HSYN, t[1]); end
            compared++; if (VSYN !== t[0]) begin mism++; $display("FAIL clamp_vsyn n=%0d got %b exp %b", n, VSYN, t[0]); end
            compared++; if (oRGB !== exp_rgb(n)) begin mism++; $display("FAIL clamp_rgb n=%0d got %h exp %h", n, oRGB, exp_rgb(n)); end
        end
    endtask

    // PCEN one-in-4: everything holds between ticks, strobes stay 1 MCLK
    task automatic test_sparse_pcen();
        logic [3:0] t;
        for (int c = 0; c < 400; c++) begin
            step(c % 4 == 3, 1'b0);
            t = exp_tim(n);
            compared++; if (HPOS !== 6'((n % 48) + 2)) begin mism++; $display("FAIL sp_hpos c=%0d got %0d exp %0d", c, HPOS, (n % 48) + 2); end
            compared++; if (LSTB !== (ticked && n % 48 == 0)) begin mism++; $display("FAIL sp_lstb c=%0d got %b", c, LSTB); end
            compared++; if (FSTB !== (ticked && n % 960 == 0)) begin mism++; $display("FAIL sp_fstb c=%0d got %b", c, FSTB); end
            compared++; if ({HBLK, VBLK, HSYN, VSYN} !== t) begin mism++; $display("FAIL sp_tim c=%0d got %b%b%b%b exp %b", c, HBLK, VBLK, HSYN, VSYN, t); end
            compared++; if (oRGB !== exp_rgb(n)) begin mism++; $display("FAIL sp_rgb c=%0d got %h exp %h", c, oRGB, exp_rgb(n)); end
        end
    endtask

    // Reset mid-frame at line 5, pixel 20, then restart from zero
    task automatic test_reset_mid();
        int budget = 1200;
        logic [3:0] t;
        while (!(n % 48 == 20 && (n / 48) % 20 == 5) && budget > 0) begin
            step(1'b1, 1'b0);
            budget--;
        end
        compared++; if (budget == 0) begin mism++; $display("FAIL rm_reach got n=%0d exp position 5/20", n); end
        HOFFS = 5'd3;
        VOFFS = 3'd1;
        step(1'b1, 1'b1);
        compared++; if (HPOS !== 6'd2) begin mism++; $display("FAIL rm_hpos got %0d exp 2", HPOS); end
        compared++; if (VPOS !== 5'd0) begin mism++; $display("FAIL rm_vpos got %0d exp 0", VPOS); end
        compared++; if ({HBLK, VBLK, HSYN, VSYN} !== 4'b1111) begin mism++; $display("FAIL rm_tim got %b%b%b%b exp 1111", HBLK, VBLK, HSYN, VSYN); end
        compared++; if (oRGB !== 12'h000) begin mism++; $display("FAIL rm_rgb got %h exp 000", oRGB); end
        step(1'b0, 1'b0);
        compared++; if (HPOS !== 6'd2) begin mism++; $display("FAIL rm_hold got %0d exp 2", HPOS); end
        for (int c = 0; c < 200; c++) begin
            step(1'b1, 1'b0);
            t = exp_tim(n);
            compared++; if (HPOS !== 6'((n % 48) + 2)) begin mism++; $display("FAIL rm_run_hpos n=%0d got %0d exp %0d", n, HPOS, (n % 48) + 2); end
            compared++; if ({HBLK, VBLK, HSYN, VSYN} !== t) begin mism++; $display("FAIL rm_run_tim n=%0d got %b%b%b%b exp %b", n, HBLK, VBLK, HSYN, VSYN, t); end
            compared++; if (oRGB !== exp_rgb(n)) begin mism++; $display("FAIL rm_run_rgb n=%0d got %h exp %h", n, oRGB, exp_rgb(n)); end
        end
    endtask

    initial begin
        test_reset();
        test_counters();
        test_sync_offset();
        test_clamp_rgb();
        test_sparse_pcen();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
